// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: scan-code constants and the FIFO pop-FSM encoding.
package ps2_pkg;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  // Pop handshake states; any later FIFO consumer can reuse this encoding.
  typedef enum logic [1:0] {
    POP_IDLE = 2'd0,
    POP_POP  = 2'd1,
    POP_GAP  = 2'd2
  } pop_state_t;

  // True for either Shift key's final scan code.
  function automatic logic is_shift_code(input logic [7:0] code);
    return (code == SC_LSHIFT) || (code == SC_RSHIFT);
  endfunction

endpackage

// File: rtl/ps2_pop_ctrl.sv
// Receiver-FIFO pop handshake: IDLE -> POP -> GAP -> IDLE, one byte per 3 cycles.
// ready is ignored in POP and GAP so the FIFO status settles after each pop.
module ps2_pop_ctrl
  import ps2_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       ready,
  input  logic [7:0] data,
  output logic       nextdata_n,
  output logic       byte_stb,
  output logic [7:0] rx_byte
);

  pop_state_t state;
  pop_state_t state_next;
  logic       nextdata_n_next;

  // Next-state and strobe decode; the pop strobe is registered from the next state.
  always_comb begin
    // NOTE: every output of this block is defaulted first so no path leaves a latch.
    state_next      = state;
    nextdata_n_next = 1'b1;
    byte_stb        = 1'b0;
    case (state)
      POP_IDLE: begin
        if (ready) begin
          state_next      = POP_POP;
          nextdata_n_next = 1'b0;
        end
      end
      POP_POP: state_next = POP_GAP;
      POP_GAP: begin
        byte_stb   = 1'b1;
        state_next = POP_IDLE;
      end
      default: state_next = POP_IDLE;
    endcase
  end

  // State register and registered pop strobe, so clr forces nextdata_n high at once.
  always_ff @(posedge clk or posedge clr) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (clr) begin
      state      <= POP_IDLE;
      nextdata_n <= 1'b1;
    end else begin
      state      <= state_next;
      nextdata_n <= nextdata_n_next;
    end
  end

  // Capture the FIFO head while the pop strobe is low; it is decoded during GAP.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rx_byte <= 8'h00;
    end else if (state == POP_POP) begin
      rx_byte <= data;
    end
  end

endmodule

// File: rtl/ps2_key_parser.sv
// PS/2 scan-code parser: strips E0/F0 prefixes, emits make/break events,
// filters typematic repeats and tracks held key, press count, Shift and Caps Lock.
module ps2_key_parser
  import ps2_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ready,
  input  logic [7:0]       data,
  input  logic             overflow,
  output logic             nextdata_n,
  output logic             key_valid,
  output logic             key_break,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_held,
  output logic [CNT_W-1:0] press_count,
  output logic             shift,
  output logic             caps,
  output logic             err
);

  logic       byte_stb;
  logic [7:0] rx_byte;

  ps2_pop_ctrl u_pop (
    .clk        (clk),
    .clr        (clr),
    .ready      (ready),
    .data       (data),
    .nextdata_n (nextdata_n),
    .byte_stb   (byte_stb),
    .rx_byte    (rx_byte)
  );

  logic       ext_p;
  logic       brk_p;
  logic [7:0] held_code;
  logic       held_ext;

  logic is_final;
  logic same_key;
  logic do_make;
  logic do_break;
  logic is_mod;

  // Classify the byte being decoded this cycle.
  always_comb begin
    is_final = byte_stb && (rx_byte != SC_EXT) && (rx_byte != SC_BRK);
    same_key = key_held && (held_code == rx_byte) && (held_ext == ext_p);
    do_break = is_final && brk_p;
    // A make of the key already held is a typematic repeat and is dropped.
    do_make  = is_final && !brk_p && !same_key;
    is_mod   = !ext_p;
  end

  // Prefix flags; overflow wins so a dropped byte never glues two sequences.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ext_p <= 1'b0;
      brk_p <= 1'b0;
    end else if (overflow) begin
      ext_p <= 1'b0;
      brk_p <= 1'b0;
    end else if (byte_stb) begin
      if (rx_byte == SC_EXT) begin
        ext_p <= 1'b1;
      end else if (rx_byte == SC_BRK) begin
        brk_p <= 1'b1;
      end else begin
        ext_p <= 1'b0;
        brk_p <= 1'b0;
      end
    end
  end

  // Event outputs, held-key tracking and press counter.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      key_valid   <= 1'b0;
      key_break   <= 1'b0;
      key_code    <= 8'h00;
      key_ext     <= 1'b0;
      key_held    <= 1'b0;
      held_code   <= 8'h00;
      held_ext    <= 1'b0;
      press_count <= '0;
    end else begin
      key_valid <= do_make || do_break;
      if (do_make || do_break) begin
        key_break <= do_break;
        key_code  <= rx_byte;
        key_ext   <= ext_p;
      end
      if (do_make) begin
        key_held    <= 1'b1;
        held_code   <= rx_byte;
        held_ext    <= ext_p;
        press_count <= press_count + CNT_W'(1);
      end else if (do_break && same_key) begin
        key_held <= 1'b0;
      end
    end
  end

  // Modifier state (non-extended codes only) and sticky overflow flag.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      shift <= 1'b0;
      caps  <= 1'b0;
      err   <= 1'b0;
    end else begin
      if ((do_make || do_break) && is_mod && is_shift_code(rx_byte)) begin
        shift <= do_make;
      end
      if (do_make && is_mod && (rx_byte == SC_CAPS)) begin
        caps <= !caps;
      end
      if (overflow) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_parser.sv
// Self-checking bench: a FIFO model feeds bytes, a per-byte behavioural model
// predicts events and state, and a monitor collects the DUT's events.
module tb_ps2_key_parser;
  import ps2_pkg::*;

  typedef struct packed {
    logic       brk;
    logic [7:0] code;
    logic       ext;
    logic       held;
    logic [7:0] count;
    logic       shift;
    logic       caps;
  } ev_t;

  logic       clk = 1'b0;
  logic       clr;
  logic       ready;
  logic [7:0] data;
  logic       overflow;
  logic       nextdata_n;
  logic       key_valid;
  logic       key_break;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_held;
  logic [7:0] press_count;
  logic       shift;
  logic       caps;
  logic       err;

  int checks = 0;
  int errors = 0;

  ps2_key_parser #(.CNT_W(8)) dut (
    .clk         (clk),
    .clr         (clr),
    .ready       (ready),
    .data        (data),
    .overflow    (overflow),
    .nextdata_n  (nextdata_n),
    .key_valid   (key_valid),
    .key_break   (key_break),
    .key_code    (key_code),
    .key_ext     (key_ext),
    .key_held    (key_held),
    .press_count (press_count),
    .shift       (shift),
    .caps        (caps),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Receiver FIFO model: head visible while non-empty, popped on a low strobe.
  logic [7:0] fifo_mem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pops   = 0;

  assign ready = (wr_ptr != rd_ptr);
  assign data  = fifo_mem[rd_ptr[9:0]];

  always @(posedge clk) begin
    if (!nextdata_n) begin
      check("pop_nonempty", 32'(wr_ptr != rd_ptr), 32'd1);
      rd_ptr <= rd_ptr + 1;
      pops   <= pops + 1;
    end
  end

  // Event monitor: records every event with the state visible alongside it.
  ev_t  obs_q[$];
  logic prev_valid = 1'b0;

  always @(negedge clk) begin
    if (prev_valid) check("valid_gap", 32'(key_valid), 32'd0);
    prev_valid <= key_valid;
    if (key_valid)
      obs_q.push_back(ev_t'{key_break, key_code, key_ext, key_held, press_count, shift, caps});
  end

  // Behavioural model of the key-event rules.
  ev_t        exp_q[$];
  logic       m_ext, m_brk, m_held, m_hext, m_shift, m_caps, m_err;
  logic [7:0] m_hcode;
  int         m_count;

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_held = 0; m_hext = 0; m_hcode = 8'h00;
    m_shift = 0; m_caps = 0; m_err = 0; m_count = 0;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic same;
    if (b == SC_EXT) m_ext = 1;
    else if (b == SC_BRK) m_brk = 1;
    else begin
      same = m_held && (m_hcode == b) && (m_hext == m_ext);
      if (m_brk) begin
        if (same) m_held = 0;
        if (!m_ext && (b == SC_LSHIFT || b == SC_RSHIFT)) m_shift = 0;
        exp_q.push_back(ev_t'{1'b1, b, m_ext, m_held, 8'(m_count), m_shift, m_caps});
      end else if (!same) begin
        m_held = 1; m_hcode = b; m_hext = m_ext;
        m_count = (m_count + 1) % 256;
        if (!m_ext && (b == SC_LSHIFT || b == SC_RSHIFT)) m_shift = 1;
        if (!m_ext && b == SC_CAPS) m_caps = !m_caps;
        exp_q.push_back(ev_t'{1'b0, b, m_ext, m_held, 8'(m_count), m_shift, m_caps});
      end
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  task automatic fifo_push(input logic [7:0] b);
    fifo_mem[wr_ptr[9:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic send(input logic [7:0] b);
    fifo_push(b);
    model_byte(b);
  endtask

  // Wait (bounded) for the FIFO to empty and the last byte to be decoded.
  task automatic drain();
    int budget;
    budget = 3 * (wr_ptr - rd_ptr) + 30;
    for (int i = 0; i < budget && (wr_ptr != rd_ptr); i++) @(negedge clk);
    check("drain_timeout", 32'(wr_ptr == rd_ptr), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic compare(input string tag);
    int n;
    check({tag, "_ev_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_ev"}, 32'(obs_q[i]), 32'(exp_q[i]));
    check({tag, "_held"},  32'(key_held),    32'(m_held));
    check({tag, "_count"}, 32'(press_count), 32'(m_count));
    check({tag, "_shift"}, 32'(shift),       32'(m_shift));
    check({tag, "_caps"},  32'(caps),        32'(m_caps));
    check({tag, "_err"},   32'(err),         32'(m_err));
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_nextdata_n"}, 32'(nextdata_n), 32'd1);
    check({tag, "_valid"},      32'(key_valid),  32'd0);
    check({tag, "_break"},      32'(key_break),  32'd0);
    check({tag, "_code"},       32'(key_code),   32'h00);
    check({tag, "_ext"},        32'(key_ext),    32'd0);
    check({tag, "_held"},       32'(key_held),   32'd0);
    check({tag, "_count"},      32'(press_count), 32'd0);
    check({tag, "_shift"},      32'(shift),      32'd0);
    check({tag, "_caps"},       32'(caps),       32'd0);
    check({tag, "_err"},        32'(err),        32'd0);
  endtask

  initial begin
    int         pops_start;
    logic [7:0] code;
    logic [7:0] prev_code;
    logic       e;
    int         reps;

    clr = 1'b1;
    overflow = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    clr = 1'b0;
    @(negedge clk);

    // Make/break of 1C, with the first byte's pop/event latency checked.
    pops_start = pops;
    send(8'h1C);
    @(negedge clk);
    check("lat_pop_low", 32'(nextdata_n), 32'd0);
    @(negedge clk);
    check("lat_gap_high", 32'(nextdata_n), 32'd1);
    check("lat_gap_novalid", 32'(key_valid), 32'd0);
    @(negedge clk);
    check("lat_valid", 32'(key_valid), 32'd1);
    check("lat_code", 32'(key_code), 32'h1C);
    send(SC_BRK);
    send(8'h1C);
    drain();
    check("basic_pops", pops - pops_start, 32'd3);
    compare("basic");

    // Typematic repeats are filtered.
    send(8'h1C); send(8'h1C); send(8'h1C); send(SC_BRK); send(8'h1C);
    drain();
    compare("repeat");

    // Extended key, then its non-extended twin as a distinct make.
    send(SC_EXT); send(8'h75); send(SC_EXT); send(SC_BRK); send(8'h75);
    send(8'h75); send(SC_BRK); send(8'h75);
    drain();
    compare("ext");

    // Shift and Caps Lock tracking.
    send(SC_LSHIFT); send(8'h1C); send(SC_BRK); send(SC_LSHIFT);
    send(SC_CAPS); send(SC_BRK); send(SC_CAPS); send(SC_CAPS);
    drain();
    compare("mods");

    // Overflow drops the pending E0 prefix and sets the sticky error.
    send(SC_EXT);
    drain();
    overflow = 1'b1;
    m_ext = 0; m_brk = 0; m_err = 1;
    @(negedge clk);
    overflow = 1'b0;
    send(8'h1C);
    drain();
    check("ovf_err", 32'(err), 32'd1);
    check("ovf_ext", 32'(key_ext), 32'd0);
    compare("ovf");

    // clr during POP: everything back to reset values in the same cycle.
    fifo_push(8'h2A);
    @(negedge clk);
    check("clr_in_pop", 32'(nextdata_n), 32'd0);
    #1 clr = 1'b1;
    #1 check_reset_outputs("clr_pop");
    model_reset();
    @(negedge clk);
    clr = 1'b0;
    model_byte(8'h2A);
    drain();
    compare("after_clr");

    // Randomised make/break pairs: 256 makes wrap the counter back to 0.
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_reset();
    prev_code = 8'h00;
    for (int p = 0; p < 256; p++) begin
      code = 8'($urandom_range(1, 8'hDF));
      if (code == prev_code) code = code ^ 8'h01;
      prev_code = code;
      e    = 1'($urandom_range(0, 1));
      reps = $urandom_range(0, 2);
      for (int r = 0; r <= reps; r++) begin
        if (e) send(SC_EXT);
        send(code);
      end
      if (e) send(SC_EXT);
      send(SC_BRK);
      send(code);
      if (p % 16 == 15) begin
        drain();
        compare("rand");
      end
    end
    check("wrap_count", 32'(press_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
